// File: rtl/game_pkg.sv
// Shared game definitions: controller state encodings, spawner FSM states
// and the LFSR feedback mask used by the pseudo-random sources.
package game_pkg;

  typedef enum logic [3:0] {
    GS_TITLE = 4'd0,
    GS_READY = 4'd1,
    GS_RUN   = 4'd2,
    GS_OVER  = 4'd3
  } game_state_e;

  localparam logic [3:0] STATE_RUN = GS_RUN;

  typedef enum logic [1:0] {
    SP_IDLE,
    SP_GAP,
    SP_LAUNCH,
    SP_ACTIVE
  } spawn_state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit right-shifting Galois LFSR; shared by the obstacle
// spawner and sprite jitter.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [15:0] lfsr
);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) lfsr <= SEED;
    else        lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Schedules the single on-screen obstacle: random gap, launch, wait for the
// obstacle stage to finish, then count the clear and ramp the speed.
module obstacle_spawner
  import game_pkg::*;
#(
  parameter logic [3:0]  RUN_STATE  = STATE_RUN,
  parameter int          MIN_GAP    = 8,
  parameter logic [7:0]  SPEED_INIT = 8'd1,
  parameter logic [7:0]  SPEED_MAX  = 8'd8,
  parameter int          RAMP_EVERY = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       tick,
  input  logic [3:0] state,
  input  logic       done,
  output logic       busy,
  output logic [2:0] location,
  output logic [7:0] speed,
  output logic [7:0] cleared
);

  localparam int                RAMP_W    = $clog2(RAMP_EVERY + 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_EVERY - 1);
  localparam logic [RAMP_W-1:0] RAMP_ONE  = RAMP_W'(1);
  localparam logic [7:0]        GAP_BASE  = 8'(MIN_GAP);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] speed_step(input logic [7:0] v);
    return (v >= SPEED_MAX) ? SPEED_MAX : v + 8'd1;
  endfunction

  logic [15:0]       lfsr;
  logic              lfsr_unused;
  spawn_state_e      sp_q, sp_d;
  logic [7:0]        gap_cnt;
  logic [7:0]        gap_load;
  logic [RAMP_W-1:0] ramp_cnt;
  logic              run;
  logic              start, gap_dec, launch, clear_evt;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .CLK   (CLK),
    .RESET (RESET),
    .lfsr  (lfsr)
  );

  // Bits above [5:0] belong to other consumers of the same generator.
  assign lfsr_unused = ^lfsr[15:6];

  assign run      = (state == RUN_STATE);
  assign gap_load = GAP_BASE + {4'b0000, lfsr[5:2]};
  assign busy     = (sp_q == SP_ACTIVE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) sp_q <= SP_IDLE;
    else        sp_q <= sp_d;
  end

  // Leaving the run state outranks tick and done in every state.
  always_comb begin
    sp_d      = sp_q;
    start     = 1'b0;
    gap_dec   = 1'b0;
    launch    = 1'b0;
    clear_evt = 1'b0;
    if (!run) begin
      sp_d = SP_IDLE;
    end else begin
      case (sp_q)
        SP_IDLE: begin
          start = 1'b1;
          sp_d  = SP_GAP;
        end
        SP_GAP: begin
          if (tick) begin
            if (gap_cnt == 8'd1) sp_d    = SP_LAUNCH;
            else                 gap_dec = 1'b1;
          end
        end
        SP_LAUNCH: begin
          launch = 1'b1;
          sp_d   = SP_ACTIVE;
        end
        SP_ACTIVE: begin
          if (done) begin
            clear_evt = 1'b1;
            sp_d      = SP_GAP;
          end
        end
        default: sp_d = SP_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      gap_cnt  <= 8'd0;
      ramp_cnt <= '0;
      location <= 3'd0;
      speed    <= SPEED_INIT;
      cleared  <= 8'd0;
    end else begin
      if (start) begin
        gap_cnt  <= gap_load;
        ramp_cnt <= '0;
        speed    <= SPEED_INIT;
        cleared  <= 8'd0;
      end
      if (gap_dec) gap_cnt <= gap_cnt - 8'd1;
      if (launch)  location <= {1'b0, lfsr[1:0]};
      if (clear_evt) begin
        gap_cnt <= gap_load;
        cleared <= sat_inc8(cleared);
        if (ramp_cnt == RAMP_LAST) begin
          ramp_cnt <= '0;
          speed    <= speed_step(speed);
        end else begin
          ramp_cnt <= ramp_cnt + RAMP_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Randomized scoreboard bench for obstacle_spawner with an event-level
// reference model of the gap/launch/clear rules.
module tb_obstacle_spawner;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] state = 4'd0;
  logic       done = 1'b0;
  logic       busy;
  logic [2:0] location;
  logic [7:0] speed;
  logic [7:0] cleared;

  int checks = 0;
  int errors = 0;
  int tick_mode = 0;

  typedef struct {
    bit rise;
    int loc;
    int spd;
    int clr;
  } exp_t;
  exp_t sb[$];

  // Reference model state: phase 0 idle, 1 gap, 2 launch, 3 active.
  int          m_phase = 0;
  int          m_gap = 0;
  int          m_clears = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  always #5 CLK = ~CLK;

  obstacle_spawner dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .tick     (tick),
    .state    (state),
    .done     (done),
    .busy     (busy),
    .location (location),
    .speed    (speed),
    .cleared  (cleared)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // Speed is the initial value plus one per four clears, capped at eight.
  function automatic int exp_speed(input int clears);
    int s;
    s = 1 + clears / 4;
    return (s > 8) ? 8 : s;
  endfunction

  function automatic int exp_cleared(input int clears);
    return (clears > 255) ? 255 : clears;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic wait_busy(input logic val, input int maxc, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge CLK);
      if (busy === val) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: busy=%0b never reached %0b within %0d cycles", name, busy, val, maxc);
    end
  endtask

  // Tick generator
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      case (tick_mode)
        1:       tick = (cyc % 4 == 0);
        2:       tick = ($urandom_range(0, 2) == 0);
        3:       tick = 1'b1;
        default: tick = 1'b0;
      endcase
    end
  end

  // Reference model: predicts every busy edge and pushes it to the scoreboard.
  initial begin
    forever begin
      @(posedge CLK or negedge RESET);
      if (!RESET) begin
        m_phase  = 0;
        m_clears = 0;
        m_lfsr   = 16'hACE1;
        sb.delete();
      end else begin
        if (state != 4'd2) begin
          if (m_phase == 3) sb.push_back('{1'b0, 0, exp_speed(m_clears), exp_cleared(m_clears)});
          m_phase = 0;
        end else begin
          case (m_phase)
            0: begin
              m_clears = 0;
              m_gap    = 8 + int'(m_lfsr[5:2]);
              m_phase  = 1;
            end
            1: if (tick) begin
              m_gap--;
              if (m_gap == 0) m_phase = 2;
            end
            2: begin
              sb.push_back('{1'b1, int'(m_lfsr[1:0]), exp_speed(m_clears), exp_cleared(m_clears)});
              m_phase = 3;
            end
            3: if (done) begin
              m_clears++;
              sb.push_back('{1'b0, 0, exp_speed(m_clears), exp_cleared(m_clears)});
              m_gap   = 8 + int'(m_lfsr[5:2]);
              m_phase = 1;
            end
            default: m_phase = 0;
          endcase
        end
        m_lfsr = lfsr_next(m_lfsr);
      end
    end
  end

  // Monitor: every busy edge must match the next predicted event.
  initial begin
    exp_t e;
    bit   prev;
    int   cur_loc;
    prev    = 1'b0;
    cur_loc = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        prev = 1'b0;
      end else begin
        if (busy !== prev) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_busy_edge: busy=%0b with no predicted event at %0t", busy, $time);
          end else begin
            e = sb.pop_front();
            check("edge_kind", int'(busy), int'(e.rise));
            check("edge_speed", int'(speed), e.spd);
            check("edge_cleared", int'(cleared), e.clr);
            if (e.rise) begin
              check("launch_location", int'(location), e.loc);
              cur_loc = e.loc;
            end
          end
        end else if (busy && prev) begin
          check("location_stable", int'(location), cur_loc);
        end
        prev = busy;
      end
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    RESET = 1'b1;

    // Idle with the game not running
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      check("idle_busy", int'(busy), 0);
      check("idle_speed", int'(speed), 1);
      check("idle_cleared", int'(cleared), 0);
      check("idle_location", int'(location), 0);
    end

    // First launch, done never returned
    state     = 4'd2;
    tick_mode = 1;
    wait_busy(1'b1, 400, "first_rise");
    repeat (60) @(negedge CLK);
    check("busy_held_without_done", int'(busy), 1);

    // Forty obstacles, done five cycles after each launch
    for (int i = 1; i <= 40; i++) begin
      wait_busy(1'b1, 400, "rise_in_sequence");
      repeat (4) @(negedge CLK);
      done = 1'b1;
      @(negedge CLK);
      done = 1'b0;
      wait_busy(1'b0, 4, "fall_after_done");
      check("cleared_sequence", int'(cleared), i);
      if (i == 3)  check("speed_before_first_ramp", int'(speed), 1);
      if (i == 4)  check("speed_first_ramp", int'(speed), 2);
      if (i == 28) check("speed_reaches_max", int'(speed), 8);
      if (i == 40) check("speed_holds_max", int'(speed), 8);
    end

    // done together with leaving the run state
    wait_busy(1'b1, 400, "rise_before_abort");
    done  = 1'b1;
    state = 4'd3;
    @(negedge CLK);
    done = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_cleared_kept", int'(cleared), 40);
    repeat (5) @(negedge CLK);
    check("abort_cleared_held", int'(cleared), 40);
    check("abort_speed_held", int'(speed), 8);
    check("abort_no_launch", int'(busy), 0);
    state = 4'd2;
    repeat (3) @(negedge CLK);
    check("restart_cleared", int'(cleared), 0);
    check("restart_speed", int'(speed), 1);

    // done held high through gaps and two launches
    done = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_busy(1'b1, 400, "held_done_rise");
      wait_busy(1'b0, 4, "held_done_fall");
    end
    repeat (2) @(negedge CLK);
    check("held_done_two_clears", int'(cleared), 2);

    // Run clears to saturation with ticks every cycle
    tick_mode = 3;
    for (int i = 0; i < 12000 && cleared != 8'd255; i++) @(negedge CLK);
    repeat (100) @(negedge CLK);
    check("cleared_saturated", int'(cleared), 255);
    check("speed_saturated", int'(speed), 8);
    done      = 1'b0;
    tick_mode = 1;

    // Asynchronous reset while an obstacle is active
    wait_busy(1'b1, 400, "rise_before_reset");
    @(posedge CLK);
    #3 RESET = 1'b0;
    #1;
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_speed", int'(speed), 1);
    check("async_reset_cleared", int'(cleared), 0);
    check("async_reset_location", int'(location), 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    wait_busy(1'b1, 400, "rise_after_reset");
    repeat (4) @(negedge CLK);
    done = 1'b1;
    @(negedge CLK);
    done = 1'b0;
    wait_busy(1'b0, 4, "fall_after_reset");
    check("cleared_after_reset", int'(cleared), 1);

    // Randomized traffic with occasional run drops
    tick_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      done  = ($urandom_range(0, 5) == 0);
      state = ($urandom_range(0, 199) == 0) ? 4'd3 : 4'd2;
    end

    state = 4'd0;
    done  = 1'b0;
    repeat (5) @(negedge CLK);
    check("final_busy", int'(busy), 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
